multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute
// plus combinational immediate-select and ALU-operation decode.
module multicycle_control (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic [2:0] immsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] resultsrc_o,
  output logic       adrsrc_o,
  output logic       irwrite_o,
  output logic       pcwrite_o,
  output logic       regwrite_o,
  output logic       memwrite_o,
  output logic [2:0] alucontrol_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;
  logic       irwrite_raw, pcwrite_raw, regwrite_raw, memwrite_raw;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // sub only for R-type (op[5]) with funct7b5; addi ignores funct7b5
  always_comb begin
    alu_dec = 3'b000;
    case (funct3_i)
      3'b000:  alu_dec = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    case (op_i)
      OP_SW:   immsrc_o = 3'b001;
      OP_BEQ:  immsrc_o = 3'b010;
      OP_JAL:  immsrc_o = 3'b011;
      OP_LUI:  immsrc_o = 3'b100;
      default: immsrc_o = 3'b000;
    endcase
  end

  always_comb begin
    alusrca_o    = 2'b00;
    alusrcb_o    = 2'b00;
    resultsrc_o  = 2'b00;
    adrsrc_o     = 1'b0;
    alucontrol_o = 3'b000;
    irwrite_raw  = 1'b0;
    pcwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        irwrite_raw = 1'b1;
        pcwrite_raw = 1'b1;
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
      end
      S_MEMADR: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      S_MEMREAD: adrsrc_o = 1'b1;
      S_MEMWB: begin
        resultsrc_o  = 2'b01;
        regwrite_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_o     = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_o    = 2'b10;
        alucontrol_o = alu_dec;
      end
      S_EXECUTEI: begin
        alusrca_o    = 2'b10;
        alusrcb_o    = 2'b01;
        alucontrol_o = alu_dec;
      end
      S_ALUWB: regwrite_raw = 1'b1;
      S_JAL: begin
        alusrca_o   = 2'b01;
        alusrcb_o   = 2'b10;
        pcwrite_raw = 1'b1;
      end
      S_BEQ: begin
        alusrca_o    = 2'b10;
        alucontrol_o = 3'b001;
        pcwrite_raw  = zero_i;
      end
      S_LUI: begin
        resultsrc_o  = 2'b11;
        regwrite_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // FETCH is the reset state, so its enables must be masked while reset is held
  assign irwrite_o  = irwrite_raw  & ~reset_i;
  assign pcwrite_o  = pcwrite_raw  & ~reset_i;
  assign regwrite_o = regwrite_raw & ~reset_i;
  assign memwrite_o = memwrite_raw & ~reset_i;
  assign state_o    = state_q;
  assign illegal_o  = (state_q == S_ERROR);

endmodule
